rr_stream_arbiter: RTL and testbench
====================================

RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 Parameter DW, default 8: data width per requester, DW >= 1.
REQ-002 Parameter N, default 4: number of requesters, N >= 2.
REQ-003 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port i_valid, input, N: per-requester beat valid.
REQ-006 Port i_last, input, N: per-requester end-of-packet flag, qualified by i_valid.
REQ-007 Port i_data, input, N*DW: requester j data in bits [(j+1)*DW-1 -: DW].
REQ-008 Port i_ready, output, N: per-requester beat accept.
REQ-009 Port o_valid, output, 1: registered output beat valid.
REQ-010 Port o_ready, input, 1: downstream accept.
REQ-011 Port o_data, output, DW: registered output data.
REQ-012 Port o_last, output, 1: registered end-of-packet.
REQ-013 Port o_id, output, IW = $clog2(N): index of the requester that sourced the output beat.

Function
REQ-014 Handshake: a beat transfers on any interface in a cycle where its valid and ready are both 1.
REQ-015 States: ARB (no packet in progress) and LOCK (packet in progress); encoding is one bit.
REQ-016 In ARB, the effective grant is the one-hot round-robin winner among i_valid: the first set bit searched upward from index ptr, wrapping at N-1 to 0.
REQ-017 In LOCK, the effective grant is the held one-hot register gnt_q, independent of i_valid.
REQ-018 Output stage can load when (!o_valid || o_ready); i_ready = effective grant AND can-load, one-hot or zero.
REQ-019 i_ready does not depend on i_valid of the granted requester beyond the ARB selection; no combinational path exists from o_ready to o_valid.
REQ-020 On an accepted input beat, o_data/o_last/o_id load the granted requester's data/last/index and o_valid becomes 1 the next cycle; latency is 1 cycle.
REQ-021 When o_ready=1 and no input beat is accepted, o_valid clears next cycle; when o_valid=1 and o_ready=0, o_data/o_last/o_id hold.
REQ-022 An accepted beat with last=0 enters or stays in LOCK, and gnt_q is set to the effective grant.
REQ-023 An accepted beat with last=1 returns to ARB and sets ptr = (winner index + 1) mod N.
REQ-024 A single-beat packet (last=1 accepted in ARB) does not enter LOCK and advances ptr.
REQ-025 In LOCK, de-assertion of the locked requester's i_valid holds LOCK; other requesters stay ungranted.
REQ-026 If no i_valid is set in ARB, grant is zero and ptr is unchanged.
REQ-027 Data selection uses a one-hot mux driven by the effective grant; a zero grant yields zero data.

Reset
REQ-028 While rst=1 at a clock edge: state=ARB, ptr=0, gnt_q=0, o_valid=0, o_data=0, o_last=0, o_id=0.
REQ-029 While rst=1, i_ready=0 combinationally; reset mid-packet abandons the packet with no flush beat.

Structure
REQ-030 The state enum (ARB/LOCK) is declared in package rr_stream_arbiter_pkg; widths derive from parameters locally.
REQ-031 One sub-module instance, onehot_mux (DW, N), performs data selection; the round-robin search is in-module.
REQ-032 Target size is 120-400 lines of RTL.

Verification (N=4, DW=8)
REQ-033 Requesters 0 and 2 each offer single-beat packets continuously, o_ready=1 -> o_id sequence 0,2,0,2; one beat per cycle after the first 1-cycle latency.
REQ-034 Requester 1 sends a 3-beat packet (0x11,0x12,0x13 last) while requester 3 is valid -> o_data 0x11,0x12,0x13 contiguous with o_id=1, then 0x3x with o_id=3.
REQ-035 o_valid=1 with o_data=0xA5 and o_ready=0 for 5 cycles -> o_data stays 0xA5, every i_ready=0, and no beat is lost when o_ready returns to 1.
REQ-036 All four requesters valid after reset with o_ready=1 -> grants in order 0,1,2,3,0; ptr wraps from 3 to 0.
REQ-037 rst asserted mid-packet from requester 2 -> next cycle o_valid=0 and state=ARB; after release, requester 0 (ptr=0) wins when valid.
REQ-038 Locked requester 1 drops i_valid for 3 cycles mid-packet while requester 0 is valid -> no beat from 0 appears until 1 finishes its last beat.

Source files
------------

// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet stream arbiter.
// Bus widths are derived locally from each module's parameters.
package rr_stream_arbiter_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Increment an index and wrap it back to zero at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_onehot_mux.sv
// AND-OR data selector for N lanes of DW bits, steered by a one-hot select.
// An all-zero select yields all-zero data.
module onehot_mux #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic [N-1:0]    sel,
  input  logic [N*DW-1:0] data,
  output logic [DW-1:0]   y
);

  always_comb begin
    y = '0;
    for (int j = 0; j < N; j++) begin
      y = y | (data[j*DW +: DW] & {DW{sel[j]}});
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Packet-aware round-robin arbiter: N valid/ready streams merged into one registered output.
// The current winner keeps the grant until its last beat has been accepted.
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         i_valid,
  input  logic [N-1:0]         i_last,
  input  logic [N*DW-1:0]      i_data,
  output logic [N-1:0]         i_ready,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [DW-1:0]        o_data,
  output logic                 o_last,
  output logic [$clog2(N)-1:0] o_id,
  output arb_state_e           state,
  output logic [$clog2(N)-1:0] ptr
);

  localparam int IW = $clog2(N);

  // Handshake: a beat moves on any port in a cycle where its valid and ready are
  // both 1. i_ready comes only from the grant and output-stage space, never from
  // o_valid of the next cycle, and o_valid is driven purely from a register.

  arb_state_e     state_q;
  logic [IW-1:0]  ptr_q;
  logic [N-1:0]   gnt_q;
  logic [N-1:0]   rr_gnt;
  logic [N-1:0]   eff_gnt;
  logic [IW-1:0]  gnt_idx;
  logic [DW-1:0]  mux_data;
  logic           sel_last;
  logic           can_load;
  logic           accept;

  // First requesting index at or above ptr, wrapping from N-1 back to 0.
  always_comb begin : rr_search
    logic          found;
    logic [IW-1:0] idx;
    int            s;
    rr_gnt = '0;
    found  = 1'b0;
    idx    = '0;
    s      = 0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr_q) + k;
      if (s >= N) s = s - N;
      idx = IW'(s);
      if (!found && i_valid[idx]) begin
        rr_gnt[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign eff_gnt = (state_q == LOCK) ? gnt_q : rr_gnt;

  always_comb begin
    gnt_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (eff_gnt[j]) gnt_idx = gnt_idx | IW'(j);
    end
  end

  onehot_mux #(
    .DW(DW),
    .N (N)
  ) u_mux (
    .sel (eff_gnt),
    .data(i_data),
    .y   (mux_data)
  );

  assign can_load = !o_valid || o_ready;
  assign i_ready  = rst ? '0 : (eff_gnt & {N{can_load}});
  assign accept   = |(i_ready & i_valid);
  assign sel_last = |(eff_gnt & i_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      gnt_q   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_id    <= '0;
    end else begin
      if (accept) begin
        o_valid <= 1'b1;
        o_data  <= mux_data;
        o_last  <= sel_last;
        o_id    <= gnt_idx;
        if (sel_last) begin
          // Packet complete: release the lock and rotate priority past the winner.
          state_q <= ARB;
          gnt_q   <= '0;
          ptr_q   <= IW'(wrap_inc(int'(gnt_idx), N));
        end else begin
          state_q <= LOCK;
          gnt_q   <= eff_gnt;
        end
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign state = state_q;
  assign ptr   = ptr_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Self-checking bench for rr_stream_arbiter (N=4, DW=8): a per-cycle vector table
// plus packet sequences checked through an expected-beat queue.
module tb_rr_stream_arbiter;
  import rr_stream_arbiter_pkg::*;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam logic [N*DW-1:0] DATA_C = 32'h3322_1100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      i_valid, i_last, i_ready;
  logic [N*DW-1:0]   i_data;
  logic              o_valid, o_ready, o_last;
  logic [DW-1:0]     o_data;
  logic [IW-1:0]     o_id, ptr;
  arb_state_e        state;

  rr_stream_arbiter #(.DW(DW), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .i_last (i_last),
    .i_data (i_data),
    .i_ready(i_ready),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_last (o_last),
    .o_id   (o_id),
    .state  (state),
    .ptr    (ptr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected output beats {id, last, data}; per-requester sources hold {last, data}.
  logic [10:0] exp_q[$];
  logic [8:0]  src_q[N][$];
  int          out_cyc_q[$];
  logic [N-1:0] hold = '0;
  logic [N-1:0] acc_n = '0;
  logic        src_mode = 1'b0;
  logic        sb_en = 1'b0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] id;
    logic       olast;
  } vec_t;
  vec_t vecs[14];

  function automatic logic [10:0] beat(input int id, input logic last, input logic [7:0] d);
    return {IW'(id), last, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_inputs();
    logic [8:0] h;
    for (int j = 0; j < N; j++) begin
      if (src_q[j].size() > 0 && !hold[j]) begin
        h = src_q[j][0];
        i_valid[j] = 1'b1;
        i_last[j]  = h[8];
        i_data[j*DW +: DW] = h[7:0];
      end else begin
        i_valid[j] = 1'b0;
        i_last[j]  = 1'b0;
        i_data[j*DW +: DW] = '0;
      end
    end
  endtask

  function automatic bit srcs_busy();
    for (int j = 0; j < N; j++) if (src_q[j].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Sample accepts and output beats away from the active edge.
  always @(negedge clk) begin
    logic [10:0] e;
    cyc++;
    acc_n = i_valid & i_ready;
    if (sb_en && o_valid && o_ready) begin
      checks++;
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual id=%0d last=%0d data=%h required no beat",
                 o_id, o_last, o_data);
      end else begin
        e = exp_q.pop_front();
        if ({o_id, o_last, o_data} !== e) begin
          failures++;
          $display("FAIL sb_beat actual id=%0d last=%0d data=%h required id=%0d last=%0d data=%h",
                   o_id, o_last, o_data, e[10:9], e[8], e[7:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (src_mode) begin
      for (int j = 0; j < N; j++) begin
        if (acc_n[j] && src_q[j].size() > 0) void'(src_q[j].pop_front());
      end
      drive_inputs();
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    src_mode = 1'b0;
    hold = '0;
    for (int j = 0; j < N; j++) src_q[j].delete();
    exp_q.delete();
    out_cyc_q.delete();
    i_valid = '0; i_last = '0; i_data = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || srcs_busy()) && n < budget) begin
      @(posedge clk); n++;
    end
    #2;
    check({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  task automatic start_src();
    src_mode = 1'b1;
    drive_inputs();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int start_cyc;
    int n;
    i_valid = '0; i_last = '0; i_data = '0; o_ready = 1'b1;

    // Reset: inputs blocked while rst is high, then all state at reset values.
    repeat (3) @(posedge clk);
    #2;
    i_valid = '1; i_last = '1; i_data = DATA_C;
    @(negedge clk);
    check("rst_i_ready", i_ready, 0);
    @(posedge clk); #2;
    i_valid = '0; i_last = '0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_last", o_last, 0);
    check("rst_o_id", o_id, 0);
    check("rst_state", 32'(state), 32'(ARB));
    check("rst_ptr", ptr, 0);

    // Per-cycle vectors: requester j presents data 8'h11*j.
    vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};
    vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b1};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1};
    vecs[5]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    vecs[6]  = '{4'b0101, 4'b1111, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{4'b0101, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1};
    vecs[8]  = '{4'b0101, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b1};
    vecs[9]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1};
    vecs[10] = '{4'b0001, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[11] = '{4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0};
    vecs[12] = '{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b1};
    vecs[13] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    for (int r = 0; r < 14; r++) begin
      @(posedge clk); #2;
      i_valid = vecs[r].valid;
      i_last  = vecs[r].last;
      o_ready = vecs[r].ordy;
      i_data  = DATA_C;
      @(negedge clk);
      check($sformatf("tbl%0d_i_ready", r), i_ready, vecs[r].rdy);
      check($sformatf("tbl%0d_o_valid", r), o_valid, vecs[r].ov);
      if (vecs[r].ov) begin
        check($sformatf("tbl%0d_o_id", r), o_id, vecs[r].id);
        check($sformatf("tbl%0d_o_last", r), o_last, vecs[r].olast);
        check($sformatf("tbl%0d_o_data", r), o_data, 8'(vecs[r].id) * 8'h11);
      end
    end

    // Requesters 0 and 2 alternate single-beat packets at full rate.
    do_reset();
    sb_en = 1'b1;
    o_ready = 1'b1;
    start_cyc = cyc;
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back({1'b1, 8'hA0 + 8'(k)});
      src_q[2].push_back({1'b1, 8'hC0 + 8'(k)});
      exp_q.push_back(beat(0, 1'b1, 8'hA0 + 8'(k)));
      exp_q.push_back(beat(2, 1'b1, 8'hC0 + 8'(k)));
    end
    start_src();
    wait_drain("alt", 40);
    check("alt_beats", out_cyc_q.size(), 8);
    if (out_cyc_q.size() == 8) begin
      check("alt_latency", out_cyc_q[0] - start_cyc, 2);
      check("alt_span", out_cyc_q[7] - out_cyc_q[0], 7);
    end

    // Three-beat packet from 1 holds the grant ahead of waiting requester 3.
    do_reset();
    out_cyc_q.delete();
    src_q[1].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b0, 8'h12});
    src_q[1].push_back({1'b1, 8'h13});
    src_q[3].push_back({1'b1, 8'h30});
    src_q[3].push_back({1'b1, 8'h31});
    exp_q.push_back(beat(1, 1'b0, 8'h11));
    exp_q.push_back(beat(1, 1'b0, 8'h12));
    exp_q.push_back(beat(1, 1'b1, 8'h13));
    exp_q.push_back(beat(3, 1'b1, 8'h30));
    exp_q.push_back(beat(3, 1'b1, 8'h31));
    start_src();
    wait_drain("pkt", 40);
    check("pkt_beats", out_cyc_q.size(), 5);
    if (out_cyc_q.size() == 5) check("pkt_contig", out_cyc_q[2] - out_cyc_q[0], 2);

    // Output stall for five cycles: data held, no input accepted, nothing lost.
    do_reset();
    o_ready = 1'b0;
    src_q[0].push_back({1'b1, 8'hA5});
    src_q[0].push_back({1'b1, 8'h5A});
    exp_q.push_back(beat(0, 1'b1, 8'hA5));
    exp_q.push_back(beat(0, 1'b1, 8'h5A));
    start_src();
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!o_valid && n < 10);
    check("stall_o_valid_seen", o_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_o_data", k), o_data, 8'hA5);
      check($sformatf("stall%0d_o_valid", k), o_valid, 1);
      check($sformatf("stall%0d_i_ready", k), i_ready, 0);
    end
    @(posedge clk); #2;
    o_ready = 1'b1;
    wait_drain("stall", 40);

    // Locked requester 1 pauses mid-packet; requester 0 must wait for its last beat.
    do_reset();
    src_q[1].push_back({1'b0, 8'h21});
    src_q[1].push_back({1'b0, 8'h22});
    src_q[1].push_back({1'b1, 8'h23});
    exp_q.push_back(beat(1, 1'b0, 8'h21));
    exp_q.push_back(beat(1, 1'b0, 8'h22));
    exp_q.push_back(beat(1, 1'b1, 8'h23));
    exp_q.push_back(beat(0, 1'b1, 8'h01));
    start_src();
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (src_q[1].size() != 2 && n < 10);
    check("lock_first_beat", src_q[1].size(), 2);
    hold[1] = 1'b1;
    src_q[0].push_back({1'b1, 8'h01});
    drive_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("lock%0d_i_ready", k), i_ready, 4'b0010);
      check($sformatf("lock%0d_state", k), 32'(state), 32'(LOCK));
    end
    @(posedge clk); #2;
    hold[1] = 1'b0;
    drive_inputs();
    wait_drain("lock", 40);

    // Reset in the middle of a packet from requester 2 abandons it.
    do_reset();
    src_q[2].push_back({1'b0, 8'h41});
    src_q[2].push_back({1'b0, 8'h42});
    src_q[2].push_back({1'b1, 8'h43});
    exp_q.push_back(beat(2, 1'b0, 8'h41));
    start_src();
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (src_q[2].size() != 2 && n < 10);
    check("mid_rst_first_beat", src_q[2].size(), 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_i_ready", i_ready, 0);
    @(posedge clk); #2;
    src_q[2].delete();
    drive_inputs();
    @(negedge clk);
    check("mid_rst_o_valid", o_valid, 0);
    check("mid_rst_state", 32'(state), 32'(ARB));
    check("mid_rst_ptr", ptr, 0);
    check("mid_rst_exp_left", exp_q.size(), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    src_q[0].push_back({1'b1, 8'h50});
    src_q[2].push_back({1'b1, 8'h60});
    exp_q.push_back(beat(0, 1'b1, 8'h50));
    exp_q.push_back(beat(2, 1'b1, 8'h60));
    drive_inputs();
    wait_drain("post_rst", 40);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
